// File: rtl/game_pkg.sv
// Shared types and encodings for the multi-channel counter game.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } game_state_e;

  localparam logic [1:0] MODE_UP1 = 2'b00;
  localparam logic [1:0] MODE_UPS = 2'b01;
  localparam logic [1:0] MODE_DN1 = 2'b10;
  localparam logic [1:0] MODE_DNS = 2'b11;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_LOS  = 2'b01;
  localparam logic [1:0] WHO_WIN  = 2'b10;

endpackage

// File: rtl/step_counter.sv
// One wrapping game counter: +1, +STEP, -1 or -STEP per enabled edge.
module step_counter
  import game_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count;
    case (mode)
      MODE_UP1: count_next = count + ONE;
      MODE_UPS: count_next = count + STEP_V;
      MODE_DN1: count_next = count - ONE;
      MODE_DNS: count_next = count - STEP_V;
      default:  count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      count <= '0;
    else if (init)  count <= load;
    else if (clear) count <= '0;
    else if (en)    count <= count_next;
  end

endmodule

// File: rtl/game_arena.sv
// N-channel counter game: per-channel counters and scores, with a central
// FSM that ends the game on the first score limit and waits for a host ack.
module game_arena
  import game_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int WIDTH       = 4,
  parameter int STEP        = 2,
  parameter int SCORE_W     = 4,
  parameter int SCORE_LIMIT = 15
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    init,
  input  logic                                    start,
  input  logic                                    ack,
  input  logic [N_CH-1:0]                         en,
  input  logic [2*N_CH-1:0]                       control,
  input  logic [WIDTH*N_CH-1:0]                   load,
  output logic [WIDTH*N_CH-1:0]                   count,
  output logic [N_CH-1:0]                         win,
  output logic [N_CH-1:0]                         los,
  output logic [SCORE_W*N_CH-1:0]                 wins,
  output logic [SCORE_W*N_CH-1:0]                 losses,
  output logic [1:0]                              state,
  output logic                                    gameover,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] who_ch,
  output logic [1:0]                              who_kind
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] LIMIT     = SCORE_W'(SCORE_LIMIT);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

  game_state_e       state_q, state_next;
  logic              play, clear, any_hit;
  logic [N_CH-1:0]   step_en, hit_win, hit_los;
  logic [CH_W-1:0]   who_ch_next;
  logic [1:0]        who_kind_next;

  assign play    = (state_q == PLAY);
  assign clear   = (state_q == OVER) && ack;
  assign step_en = play ? en : '0;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0]   cnt;
    logic [SCORE_W-1:0] wins_r, losses_r, wins_inc, losses_inc;
    logic               win_r, los_r, all_ones, is_zero;

    step_counter #(.WIDTH(WIDTH), .STEP(STEP)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .init  (init),
      .clear (clear),
      .en    (step_en[i]),
      .mode  (control[2*i +: 2]),
      .load  (load[WIDTH*i +: WIDTH]),
      .count (cnt)
    );

    // Scoring looks at the count before this edge's update.
    assign all_ones   = &cnt;
    assign is_zero    = ~|cnt;
    assign wins_inc   = sat_inc(wins_r);
    assign losses_inc = sat_inc(losses_r);
    assign hit_win[i] = step_en[i] && all_ones && (wins_inc == LIMIT);
    assign hit_los[i] = step_en[i] && is_zero && (losses_inc == LIMIT);

    always_ff @(posedge clk) begin
      if (reset || init || clear) begin
        wins_r   <= '0;
        losses_r <= '0;
        win_r    <= 1'b0;
        los_r    <= 1'b0;
      end else if (step_en[i]) begin
        if (all_ones) begin
          win_r  <= 1'b1;
          los_r  <= 1'b0;
          wins_r <= wins_inc;
        end else if (is_zero) begin
          win_r    <= 1'b0;
          los_r    <= 1'b1;
          losses_r <= losses_inc;
        end else begin
          win_r <= 1'b0;
          los_r <= 1'b0;
        end
      end
    end

    assign count[WIDTH*i +: WIDTH]    = cnt;
    assign wins[SCORE_W*i +: SCORE_W]   = wins_r;
    assign losses[SCORE_W*i +: SCORE_W] = losses_r;
    assign win[i] = win_r;
    assign los[i] = los_r;
  end

  // Walk downward so the lowest hitting channel is the one that sticks.
  always_comb begin
    any_hit       = 1'b0;
    who_ch_next   = '0;
    who_kind_next = WHO_NONE;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit_win[i] || hit_los[i]) begin
        any_hit       = 1'b1;
        who_ch_next   = CH_W'(i);
        who_kind_next = hit_win[i] ? WHO_WIN : WHO_LOS;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    if (init) begin
      state_next = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)   state_next = PLAY;
        PLAY:    if (any_hit) state_next = OVER;
        OVER:    if (ack)     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || init || clear) begin
      who_ch   <= '0;
      who_kind <= WHO_NONE;
    end else if (play && any_hit) begin
      who_ch   <= who_ch_next;
      who_kind <= who_kind_next;
    end
  end

  assign state    = state_q;
  assign gameover = (state_q == OVER);

endmodule

// File: doc/game_arena.md
Name: game_arena

Overview:
- N-channel successor to the single counter game block.
- Each channel owns a WIDTH-bit multi-mode counter with a programmable large step, plus a win-hit and loss-hit score counter.
- A central FSM (IDLE/PLAY/OVER) arbitrates game-over across channels and holds the result until a host acknowledge handshake.
- Sits under the game top level, driven by the player-control logic.

Parameters:
- N_CH, 2, number of independent channels (1..8).
- WIDTH, 4, counter width per channel.
- STEP, 2, magnitude of the large step (1..2^WIDTH-1).
- SCORE_W, 4, width of each win/loss score counter.
- SCORE_LIMIT, 15, score value that ends the game (1..2^SCORE_W-1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- init  in  1  load counters, clear scores, go IDLE
- start  in  1  IDLE->PLAY request
- ack  in  1  host acknowledge of game-over
- en  in  N_CH  per-channel count enable
- control  in  2*N_CH  per-channel mode, channel i at [2i+1:2i]
- load  in  WIDTH*N_CH  per-channel init value
- count  out  WIDTH*N_CH  per-channel counter values
- win  out  N_CH  channel counter was all-ones on the last PLAY edge
- los  out  N_CH  channel counter was zero on the last PLAY edge
- wins  out  SCORE_W*N_CH  per-channel win scores
- losses  out  SCORE_W*N_CH  per-channel loss scores
- state  out  2  00 IDLE, 01 PLAY, 10 OVER
- gameover  out  1  high exactly while in OVER
- who_ch  out  max(1,$clog2(N_CH))  index of the deciding channel
- who_kind  out  2  00 none, 01 loser limit, 10 winner limit

Behaviour:
- Reset: all outputs and internal registers 0; state IDLE. Reset is honoured in any state, including mid-game.
- Priority on every edge: reset > init > FSM.
- init: count_i <= load_i; scores, win, los, who_* cleared; state IDLE. Counters do not move on an init edge.
- IDLE: counters hold. start=1 -> PLAY on the next edge.
- PLAY, per channel with en_i=1, counter update by control:
  - 00: +1
  - 01: +STEP
  - 10: -1
  - 11: -STEP
  - Arithmetic is modulo 2^WIDTH (wrap, no saturation).
- PLAY, per channel with en_i=0: counter, win and los hold.
- PLAY scoring uses the pre-update count of each enabled channel:
  - All-ones: win_i<=1, los_i<=0, wins_i+1.
  - Zero: los_i<=1, win_i<=0, losses_i+1.
  - Otherwise: both flags cleared.
- Scores saturate at 2^SCORE_W-1.
- End of game: on the edge where any channel's incremented score equals SCORE_LIMIT, state <= OVER (1-cycle latency).
  - who_ch = lowest such channel index.
  - who_kind = 10 if that channel hit the win limit, 01 if it hit the loss limit.
  - Among simultaneous hits, the lowest channel index is decided first; win vs loss cannot coincide on one channel.
- OVER: gameover=1; counters, scores, flags and who_* frozen; start ignored.
- ack=1 in OVER -> next edge clears counters, scores, flags and who_*, and sets state IDLE (gameover drops the same edge).
- ack is ignored outside OVER. start is ignored in PLAY.

Decomposition:
- Package game_pkg holds:
  - state enum game_state_e {IDLE, PLAY, OVER}
  - mode constants MODE_UP1, MODE_UPS, MODE_DN1, MODE_DNS
  - who_kind constants WHO_NONE, WHO_LOS, WHO_WIN
- Sub-module step_counter (WIDTH, STEP): one channel counter with init, load, en and mode, instantiated N_CH times via generate.
- Scoring, arbitration and the FSM stay in game_arena.

Test Plan (defaults: N_CH=2, WIDTH=4, STEP=2, limit 15):
- reset mid-PLAY with counts 7/9 -> next edge all outputs 0, state IDLE.
- init with load={ch1=3, ch0=14}, start, ch0 mode 00 -> ch0 sequence 14,15,0,1; win0 high one cycle after count0=15, los0 high one cycle after count0=0.
- Wrap checks:
  - ch1 mode 11 from load 1 -> 1, 15, 13; no loss counted.
  - ch1 mode 01 from 14 -> 0.
- Preload wins0=14 via repeated laps, then the next all-ones edge -> wins0=15, state OVER, gameover=1, who_ch=0, who_kind=10; counts frozen over 5 cycles of en=1.
- Both channels reach limit on the same edge (ch0 win, ch1 loss) -> who_ch=0, who_kind=10.
- Handshake:
  - In OVER, start=1 has no effect.
  - ack=1 -> next edge state IDLE, gameover=0, all scores 0.
  - ack pulsed in PLAY is ignored.
